// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants for the hazard/stall logic: Tuse/Tnew encodings,
// the hardwired-zero register and the default mult/div latencies.
package cpu_pipe_pkg;

    // Tuse value meaning "this operand is never read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew encodings: cycles until a producer's result can be forwarded
    localparam logic [1:0] TNEW_READY = 2'd0;
    localparam logic [1:0] TNEW_ONE   = 2'd1;
    localparam logic [1:0] TNEW_TWO   = 2'd2;

    // $zero never carries a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Busy latencies of the mult/div unit, counted from the issue edge
    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    // One operand against one producer: stall when the value is needed
    // sooner than the producer can supply it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return (src == dst) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the datapath (master) and the stall controller (slave).
interface hazard_stall_ctrl_if;

    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       md_use_D;
    logic [4:0] dst_E;
    logic [1:0] tnew_E;
    logic [4:0] dst_M;
    logic [1:0] tnew_M;
    logic       md_start_E;
    logic       md_is_div_E;
    logic       pc_en;
    logic       d_en;
    logic       e_clr;
    logic       md_busy;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        output dst_E, tnew_E, dst_M, tnew_M, md_start_E, md_is_div_E,
        input  pc_en, d_en, e_clr, md_busy
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        input  dst_E, tnew_E, dst_M, tnew_M, md_start_E, md_is_div_E,
        output pc_en, d_en, e_clr, md_busy
    );

endinterface

// File: rtl/hazard_stall_ctrl_md_busy_seq.sv
// Mult/div busy sequencer: loads a latency on issue, counts down to idle,
// and presents a registered busy flag that is high for exactly that many cycles.
module md_busy_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    // Latencies are deliberately truncated to the counter width
    localparam logic [CNT_W-1:0] MULT_LOAD = MULT_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DIV_LOAD  = DIV_CYCLES[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             busy_reg;
    logic             busy_next;

    // State register: reset wins over any load in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            busy_reg <= busy_next;
        end
    end

    // Next state: decrement while busy (never below zero), load only when idle
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end else if (md_start) begin
            cnt_next = md_is_div ? DIV_LOAD : MULT_LOAD;
        end
        busy_next = (cnt_next != '0);
    end

    // Output: busy flag straight from its register
    always_comb begin
        md_busy = busy_reg;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall controller for the five-stage pipeline. Combines Tuse/Tnew
// dependency stalls on the D instruction with the mult/div busy stall and
// drives PC enable, F/D enable and the D/E flush in the same cycle.
// Optional build macro STALL_STATS_EN adds a 32-bit stall_cycles counter port.
module hazard_stall_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave hz
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    logic [4:0] src_reg  [2];
    logic [1:0] src_tuse [2];
    logic [1:0] src_stall;
    logic       md_stall;
    logic       stall;
    logic       md_busy_int;

    assign src_reg[0]  = hz.rs_D;
    assign src_reg[1]  = hz.rt_D;
    assign src_tuse[0] = hz.tuse_rs_D;
    assign src_tuse[1] = hz.tuse_rt_D;

    // Per-operand dependency check against the E and M producers
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            always_comb begin
                src_stall[gi] = (src_reg[gi] != REG_ZERO) &&
                    (src_hazard(src_reg[gi], src_tuse[gi], hz.dst_E, hz.tnew_E) ||
                     src_hazard(src_reg[gi], src_tuse[gi], hz.dst_M, hz.tnew_M));
            end
        end
    endgenerate

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_seq (
        .clk       (clk),
        .reset     (reset),
        .md_start  (hz.md_start_E),
        .md_is_div (hz.md_is_div_E),
        .md_busy   (md_busy_int)
    );

    // A mult/div-family instruction in D waits while the unit is busy or
    // while a mult/div is issuing from E right now
    always_comb begin
        md_stall = hz.md_use_D && (md_busy_int || hz.md_start_E);
        stall    = (|src_stall) || md_stall;
    end

    // Output mapping: freeze F/D and PC, bubble E
    always_comb begin
        hz.pc_en   = ~stall;
        hz.d_en    = ~stall;
        hz.e_clr   = stall;
        hz.md_busy = md_busy_int;
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles_reg;

    // Stall-cycle counter, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (stall) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall controller for the five-stage MIPS pipeline.
- Decides each cycle whether the F/D pipeline register and PC advance, or whether a bubble is inserted into E.
- Two stall sources:
  - Tuse/Tnew register-dependency analysis on the instruction in D.
  - An internal busy sequencer tracking the multi-cycle mult/div unit.
- Sits beside the datapath. It drives the F/D enable, the PC enable and the D/E flush.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E.
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E.
- CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rs_D  in  5  rs field of instruction in D
- rt_D  in  5  rt field of instruction in D
- tuse_rs_D  in  2  cycles until D needs rs (3 = not used)
- tuse_rt_D  in  2  cycles until D needs rt (3 = not used)
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- dst_E  in  5  destination register of instruction in E (0 = none)
- tnew_E  in  2  cycles until E's result is forwardable
- dst_M  in  5  destination register in M
- tnew_M  in  2  cycles until M's result is forwardable
- md_start_E  in  1  mult/div instruction is in E this cycle
- md_is_div_E  in  1  qualifies md_start_E: 1 = div/divu
- pc_en  out  1  PC update enable
- d_en  out  1  F/D register enable
- e_clr  out  1  flush D/E register to nop
- md_busy  out  1  mult/div unit busy

Behaviour:
- Data stall (combinational), for each of rs and rt:
  - stall_rs = (rs_D != 0) && ((rs_D == dst_E && tuse_rs_D < tnew_E) || (rs_D == dst_M && tuse_rs_D < tnew_M)).
  - stall_rt is formed the same way using rt_D and tuse_rt_D.
  - Register 0 never stalls.
- MD stall: md_use_D && (md_busy || md_start_E).
- stall = stall_rs | stall_rt | md stall.
- Output mapping: pc_en = d_en = ~stall; e_clr = stall. All three are combinational and respond in the same cycle.
- Busy counter states:
  - IDLE: cnt = 0, md_busy = 0.
  - BUSY: cnt > 0, md_busy = 1.
- Transitions:
  - IDLE with md_start_E=1: cnt loads DIV_CYCLES if md_is_div_E, otherwise MULT_CYCLES, at the next edge.
  - BUSY: cnt decrements by 1 each edge. It returns to IDLE when cnt reaches 0.
  - md_busy = (cnt != 0), registered. It is first high in the cycle after the issue edge and high for exactly N cycles.
  - md_start_E while BUSY is ignored; cnt is not reloaded. This cannot occur in legal operation, because the md stall bubbles E.
- Reset values: cnt = 0, md_busy = 0. Outputs are then pc_en = 1, d_en = 1, e_clr = 0 unless the inputs demand a stall.
- Reset asserted mid-BUSY clears cnt at that edge. Reset has priority over a load.
- A stall is asserted on the same cycle that md_start_E=1 with md_use_D=1 (back-to-back mult then mflo).
- Width rules:
  - The counter never wraps below 0; decrement occurs only when cnt != 0.
  - Parameter values are truncated to CNT_W.

Optional Feature:
- STALL_STATS_EN: adds output stall_cycles (32 bits).
  - Increments by 1 on each clk edge where stall = 1 and reset = 0.
  - Reset to 0; wraps at 2^32.
- Without the macro the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pipe_pkg:
  - TUSE_NONE = 2'd3.
  - Tnew encodings.
  - Register-zero constant.
  - Default MULT_CYCLES / DIV_CYCLES.
- One natural sub-module, md_busy_seq: the counter and md_busy register. The parent keeps the combinational hazard logic.

Test Plan:
- Reset: reset=1 for 2 cycles with md_start_E=1 → md_busy=0, pc_en=d_en=1, e_clr=0 after release.
- Load-use: rs_D=8, tuse_rs_D=0, dst_E=8, tnew_E=2 → stall=1 (pc_en=0, e_clr=1). Same with rs_D=0 → stall=0.
- Tuse satisfied: rt_D=9, tuse_rt_D=1, dst_M=9, tnew_M=1 → no stall. Change tnew_M=2 → stall.
- Mult then mflo: md_start_E=1, md_is_div_E=0, md_use_D=1 → stall that cycle; md_busy high exactly 5 cycles; stall released the cycle md_busy falls.
- Div: md_start_E=1, md_is_div_E=1 → md_busy high 10 cycles. Reset pulsed at busy cycle 4 → md_busy=0 the next cycle.
- STALL_STATS_EN build: 3 data-stall cycles plus 5 md-stall cycles → stall_cycles=8.
